// File: rtl/lc3b_ctrl_pipe.sv
// lc3b_ctrl_pipe: control-word pipeline with per-stage valid, stall/hold, bubble insertion, flush and saturating bubble counter
module lc3b_ctrl_pipe #(
  parameter int WIDTH  = 40,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_ctrl,
  output logic                      in_ready,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES*WIDTH-1:0]   stage_ctrl,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_ctrl,
  output logic [CNT_W-1:0]          bubble_count
);
  logic [STAGES-1:0]             hold, hold_prev, valid_prev, v, nv;
  logic [STAGES-1:0][WIDTH-1:0]  c, ctrl_prev, nc;
  logic [CNT_W-1:0]              cnt;
  always_comb begin
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      acc     = acc | stall[i];
      hold[i] = acc;
    end
  end
  assign hold_prev  = {hold[STAGES-2:0], 1'b0};
  assign valid_prev = {v[STAGES-2:0], in_valid};
  assign ctrl_prev  = {c[STAGES-2:0], in_ctrl & {WIDTH{in_valid}}};
  always_comb begin
    nv = '0;
    nc = '0;
    for (int i = 0; i < STAGES; i++) begin
      nv[i] = !flush[i] && (hold[i] ? v[i] : !hold_prev[i] && valid_prev[i]);
      nc[i] = (flush[i] || (!hold[i] && hold_prev[i])) ? '0 : hold[i] ? c[i] : ctrl_prev[i];
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v   <= '0;
      c   <= '0;
      cnt <= '0;
    end else begin
      v <= nv;
      c <= nc;
      if (!v[STAGES-1] && !(&cnt)) cnt <= cnt + CNT_W'(1);
    end
  end
  assign in_ready     = !hold[0];
  assign stage_valid  = v;
  assign stage_ctrl   = c;
  assign out_valid    = v[STAGES-1];
  assign out_ctrl     = c[STAGES-1];
  assign bubble_count = cnt;
endmodule

// File: tb/tb_lc3b_ctrl_pipe.sv
// tb_lc3b_ctrl_pipe: table-driven, directed and randomized checks of lc3b_ctrl_pipe against a stage-array model
module tb_lc3b_ctrl_pipe;
  localparam int W = 40;
  localparam int S = 4;
  localparam int CW = 4;
  logic clk, reset_n, in_valid, in_ready, out_valid;
  logic [W-1:0] in_ctrl, out_ctrl;
  logic [S-1:0] stall, flush, stage_valid;
  logic [S*W-1:0] stage_ctrl;
  logic [CW-1:0] bubble_count;
  lc3b_ctrl_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_ready(in_ready),
    .stall(stall), .flush(flush), .stage_valid(stage_valid), .stage_ctrl(stage_ctrl),
    .out_valid(out_valid), .out_ctrl(out_ctrl), .bubble_count(bubble_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_err = 0;
  logic [S-1:0] mv;
  logic [W-1:0] mc [S];
  int mcnt;
  typedef struct packed {
    logic       rn;
    logic       iv;
    logic [7:0] ic;
    logic [3:0] st;
    logic [3:0] fl;
    logic [3:0] ev;
    logic [7:0] eo;
    logic [3:0] ecnt;
    logic       erdy;
  } vec_t;
  vec_t tbl [21];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic rn, input logic iv, input logic [W-1:0] ic, input logic [S-1:0] st, input logic [S-1:0] fl);
    reset_n = rn; in_valid = iv; in_ctrl = ic; stall = st; flush = fl;
    #1;
    chk("in_ready", 64'(in_ready), 64'(stall == '0));
  endtask
  task automatic model_update();
    int top;
    if (!reset_n) begin
      mv = '0;
      for (int i = 0; i < S; i++) mc[i] = '0;
      mcnt = 0;
    end else begin
      if (!mv[S-1] && mcnt < (1 << CW) - 1) mcnt++;
      top = -1;
      for (int j = 0; j < S; j++) if (stall[j]) top = j;
      for (int i = S-1; i > top; i--) begin
        if (i == 0) begin
          mv[0] = in_valid;
          mc[0] = in_valid ? in_ctrl : '0;
        end else if (i == top + 1) begin
          mv[i] = 1'b0;
          mc[i] = '0;
        end else begin
          mv[i] = mv[i-1];
          mc[i] = mc[i-1];
        end
      end
      for (int i = 0; i < S; i++) if (flush[i]) begin
        mv[i] = 1'b0;
        mc[i] = '0;
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    for (int i = 0; i < S; i++) begin
      chk($sformatf("valid[%0d]", i), 64'(stage_valid[i]), 64'(mv[i]));
      chk($sformatf("ctrl[%0d]", i), 64'(stage_ctrl[i*W +: W]), 64'(mc[i]));
    end
    chk("out_valid", 64'(out_valid), 64'(mv[S-1]));
    chk("out_ctrl", 64'(out_ctrl), 64'(mc[S-1]));
    chk("bubble_count", 64'(bubble_count), 64'(mcnt));
  endtask
  initial begin
    logic [W-1:0] held;
    logic iv_r;
    logic [S-1:0] st_r, fl_r;
    mv = '0; mcnt = 0;
    for (int i = 0; i < S; i++) mc[i] = '0;
    reset_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; stall = '0; flush = '0;
    tbl[0]  = '{1'b0, 1'b1, 8'd99, 4'b0000, 4'b0000, 4'b0000, 8'd0,  4'd0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 8'd99, 4'b0000, 4'b0000, 4'b0000, 8'd0,  4'd0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 8'd1,  4'b0000, 4'b0000, 4'b0001, 8'd0,  4'd1, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 8'd2,  4'b0000, 4'b0000, 4'b0011, 8'd0,  4'd2, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 8'd3,  4'b0000, 4'b0000, 4'b0111, 8'd0,  4'd3, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 8'd4,  4'b0000, 4'b0000, 4'b1111, 8'd1,  4'd4, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 8'd5,  4'b0000, 4'b0000, 4'b1111, 8'd2,  4'd4, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 8'd6,  4'b0010, 4'b0000, 4'b1011, 8'd3,  4'd4, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'd6,  4'b0010, 4'b0000, 4'b0011, 8'd0,  4'd4, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'd6,  4'b0000, 4'b0000, 4'b0111, 8'd0,  4'd5, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 8'd0,  4'b0000, 4'b0000, 4'b1110, 8'd4,  4'd6, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 8'd0,  4'b0000, 4'b0000, 4'b1100, 8'd5,  4'd6, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 8'd0,  4'b0000, 4'b0000, 4'b1000, 8'd6,  4'd6, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 8'd13, 4'b0000, 4'b0000, 4'b0001, 8'd0,  4'd6, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 8'd12, 4'b0000, 4'b0000, 4'b0011, 8'd0,  4'd7, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 8'd11, 4'b0000, 4'b0000, 4'b0111, 8'd0,  4'd8, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 8'd10, 4'b0000, 4'b0000, 4'b1111, 8'd13, 4'd9, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 8'd14, 4'b1000, 4'b0000, 4'b1111, 8'd13, 4'd9, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 8'd14, 4'b1000, 4'b0000, 4'b1111, 8'd13, 4'd9, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 8'd14, 4'b1000, 4'b0000, 4'b1111, 8'd13, 4'd9, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 8'd14, 4'b0000, 4'b0011, 4'b1100, 8'd12, 4'd9, 1'b1};
    @(posedge clk); #1;
    for (int r = 0; r < 21; r++) begin
      drive(tbl[r].rn, tbl[r].iv, W'(tbl[r].ic), tbl[r].st, tbl[r].fl);
      chk($sformatf("tbl%0d_ready", r), 64'(in_ready), 64'(tbl[r].erdy));
      tick();
      chk($sformatf("tbl%0d_valid", r), 64'(stage_valid), 64'(tbl[r].ev));
      chk($sformatf("tbl%0d_out", r), 64'(out_ctrl), 64'(tbl[r].eo));
      chk($sformatf("tbl%0d_cnt", r), 64'(bubble_count), 64'(tbl[r].ecnt));
    end
    chk("flush_s2", 64'(stage_ctrl[2*W +: W]), 64'd11);
    chk("flush_s3", 64'(stage_ctrl[3*W +: W]), 64'd12);
    chk("flush_s1", 64'(stage_ctrl[1*W +: W]), 64'd0);
    chk("flush_s0", 64'(stage_ctrl[0 +: W]), 64'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, W'(20 + k), '0, '0);
      tick();
    end
    drive(1'b1, 1'b1, W'(24), 4'b0100, 4'b0100);
    chk("fs_ready", 64'(in_ready), 64'd0);
    tick();
    chk("fs_valid", 64'(stage_valid), 64'b0011);
    chk("fs_s0", 64'(stage_ctrl[0 +: W]), 64'd23);
    chk("fs_s1", 64'(stage_ctrl[1*W +: W]), 64'd22);
    chk("fs_s2", 64'(stage_ctrl[2*W +: W]), 64'd0);
    chk("fs_s3", 64'(stage_ctrl[3*W +: W]), 64'd0);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b0, '0, '0, '0);
      tick();
    end
    chk("sat_cnt", 64'(bubble_count), 64'd15);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, W'(30 + k), '0, '0);
      tick();
    end
    chk("full_valid", 64'(stage_valid), 64'hf);
    drive(1'b0, 1'b1, W'(40), 4'b0101, 4'b0010);
    tick();
    chk("rst_valid", 64'(stage_valid), 64'd0);
    chk("rst_ctrl", 64'(stage_ctrl[63:0]), 64'd0);
    chk("rst_ctrl_hi", 64'(stage_ctrl[S*W-1:64]), 64'd0);
    chk("rst_cnt", 64'(bubble_count), 64'd0);
    held = '0; iv_r = 1'b0;
    for (int k = 0; k < 400; k++) begin
      st_r = '0; fl_r = '0;
      for (int b = 0; b < S; b++) begin
        st_r[b] = ($urandom_range(0, 99) < 15);
        fl_r[b] = ($urandom_range(0, 99) < 5);
      end
      if (!(iv_r && !in_ready)) begin
        iv_r = ($urandom_range(0, 99) < 70);
        held = {$urandom, $urandom};
      end
      drive($urandom_range(0, 99) >= 2, iv_r, held, st_r, fl_r);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
